// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bundle of the BCD converter
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int NUM_DIGITS = 3
);
  logic                              start;
  logic [IN_WIDTH-1:0]               binary;
  logic                              busy;
  logic                              done;
  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]             blank;

  modport master (output start, binary, input busy, done, bcd, blank);
  modport slave  (input start, binary, output busy, done, bcd, blank);
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational double-dabble cell: a digit of 5 or more gets +3
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);
  assign adjusted = (digit >= BCD_DIGIT_W'(ADD3_THRESH)) ? digit + BCD_DIGIT_W'(3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative shift-and-add-3 binary to packed BCD converter, one bit per clock
// Optional leading-zero blank flags when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int NUM_DIGITS = 3
)(
  input  logic i_Clk,
  input  logic i_Rst_L,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = cnt_width(IN_WIDTH);

  if (pow10(NUM_DIGITS) < (64'd1 << IN_WIDTH)) begin : g_digit_check
    $error("bin_to_bcd_seq: NUM_DIGITS too small to hold 2^IN_WIDTH-1");
  end

  state_e              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adj;
  logic [BCD_W-1:0]    scratch_nxt;
  logic [CNT_W-1:0]    cnt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top adjusted bit drops off; it is always 0 when NUM_DIGITS is sized correctly.
  assign scratch_nxt = {adj[BCD_W-2:0], shreg[IN_WIDTH-1]};

`ifdef BIN_TO_BCD_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_nxt;
  logic                  zero_above;

  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above && (scratch_nxt[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_nxt[k] = zero_above;
    end
  end
`else
  assign bus.blank = '0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.bcd  <= '0;
`ifdef BIN_TO_BCD_BLANK_EN
      bus.blank <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.binary;
            scratch  <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(IN_WIDTH - 1)) begin
            bus.bcd  <= scratch_nxt;
            bus.done <= 1'b1;
`ifdef BIN_TO_BCD_BLANK_EN
            bus.blank <= blank_nxt;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq against an arithmetic BCD model
module tb_bin_to_bcd_seq;

  localparam int IW = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #20 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) bus ();

  bin_to_bcd_seq #(.IN_WIDTH(IW), .NUM_DIGITS(ND)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  function automatic logic [4*ND-1:0] ref_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [ND-1:0] ref_blank(input int v);
    logic [ND-1:0] b;
    int lim;
    b = '0;
    lim = 1;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int k = 1; k < ND; k++) begin
      lim = lim * 10;
      b[k] = (v < lim);
    end
`endif
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with v, then observes 20 post-edge samples; sample 1 follows the accepting edge.
  task automatic convert(input logic [IW-1:0] v, output int lat, output int busy_cyc,
                         output int done_cnt, output logic [4*ND-1:0] bcd_o,
                         output logic [ND-1:0] blank_o);
    lat = 0; busy_cyc = 0; done_cnt = 0; bcd_o = 'x; blank_o = 'x;
    bus.start = 1'b1;
    bus.binary = v;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        bus.start = 1'b0;
        bus.binary = IW'($urandom);
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i;
          bcd_o = bus.bcd;
          blank_o = bus.blank;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.binary = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests_run++; if (bus.bcd !== '0) begin tests_failed++; $display("FAIL reset_bcd got %h want 0", bus.bcd); end
    tests_run++; if (bus.blank !== '0) begin tests_failed++; $display("FAIL reset_blank got %b want 0", bus.blank); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_value(input string name, input int v, input bit check_busy);
    int lat, busy_cyc, done_cnt;
    logic [4*ND-1:0] b;
    logic [ND-1:0] bl;
    convert(IW'(v), lat, busy_cyc, done_cnt, b, bl);
    tests_run++; if (lat !== IW + 1) begin tests_failed++; $display("FAIL %s_latency got %0d want %0d", name, lat, IW + 1); end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt); end
    tests_run++; if (b !== ref_bcd(v)) begin tests_failed++; $display("FAIL %s_bcd got %h want %h", name, b, ref_bcd(v)); end
    tests_run++; if (bl !== ref_blank(v)) begin tests_failed++; $display("FAIL %s_blank got %b want %b", name, bl, ref_blank(v)); end
    if (check_busy) begin
      tests_run++; if (busy_cyc !== IW + 1) begin tests_failed++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cyc, IW + 1); end
    end
    tests_run++; if (bus.bcd !== ref_bcd(v)) begin tests_failed++; $display("FAIL %s_hold got %h want %h", name, bus.bcd, ref_bcd(v)); end
  endtask

  task automatic test_busy_ignore();
    int done_cnt;
    logic [4*ND-1:0] b;
    done_cnt = 0;
    b = 'x;
    bus.start = 1'b1;
    bus.binary = 8'd99;
    for (int i = 1; i <= 25; i++) begin
      tick();
      bus.start = (i == 3);
      bus.binary = (i == 3) ? 8'd7 : 8'd0;
      if (bus.done) begin
        done_cnt++;
        b = bus.bcd;
      end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL busy_ignore_pulses got %0d want 1", done_cnt); end
    tests_run++; if (b !== ref_bcd(99)) begin tests_failed++; $display("FAIL busy_ignore_bcd got %h want %h", b, ref_bcd(99)); end
    tests_run++; if (bus.bcd !== ref_bcd(99)) begin tests_failed++; $display("FAIL busy_ignore_hold got %h want %h", bus.bcd, ref_bcd(99)); end
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    done_cnt = 0;
    bus.start = 1'b1;
    bus.binary = 8'd128;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #5 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.bcd !== '0) begin tests_failed++; $display("FAIL abort_bcd got %h want 0", bus.bcd); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    test_value("after_abort", 128, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      test_value("random", int'($urandom_range(0, 255)), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int next_v, last_cyc, cyc;
    next_v = 0;
    last_cyc = -1;
    cyc = 0;
    bus.start = 1'b1;
    bus.binary = '0;
    while (next_v < 256 && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.done) begin
        tests_run++;
        if (bus.bcd !== ref_bcd(next_v) || bus.blank !== ref_blank(next_v)) begin
          tests_failed++;
          $display("FAIL b2b_result v=%0d got %h/%b want %h/%b", next_v, bus.bcd, bus.blank, ref_bcd(next_v), ref_blank(next_v));
        end
        if (last_cyc >= 0) begin
          tests_run++;
          if (cyc - last_cyc !== IW + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing v=%0d got %0d want %0d", next_v, cyc - last_cyc, IW + 2);
          end
        end
        last_cyc = cyc;
        next_v++;
        bus.binary = IW'(next_v);
      end
    end
    bus.start = 1'b0;
    tests_run++; if (next_v !== 256) begin tests_failed++; $display("FAIL b2b_count got %0d want 256", next_v); end
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_value("zero", 0, 1'b1);
    test_value("max", 255, 1'b1);
    test_value("adder_max", 30, 1'b1);
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
